matrix_pkt_dispatch: RTL and testbench
======================================

# matrix_pkt_dispatch

Store-and-forward packet dispatcher directly upstream of the channel stages. It accepts the 32-bit matrix-memory packet stream and buffers whole packets. Each complete packet is issued gap-free to one channel stage whose `pkt_enable` is high, chosen round-robin. Output framing matches what a channel stage samples: a `sop` pulse with the first word, `vld` held through `eop`, and one word every cycle.

## Interface
- `CH_NUM`, 4: number of downstream channel stages, 1..8.
- `ADDR_W`, 10: buffer address width; depth 2^ADDR_W words, each `{eop,data}`.
- `MAX_PKT_LEN`, 256: maximum packet length in words; must be ≤ 2^ADDR_W.

Ports:
- `sys_clk` in 1: sole clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `in_sop` in 1: first word of a packet; qualified by `in_vld`.
- `in_eop` in 1: last word of a packet; qualified by `in_vld`.
- `in_vld` in 1: input word valid; gaps are allowed inside a packet.
- `in_data` in 32: input word.
- `in_ready` out 1: a new packet may start; sampled only on `in_sop`.
- `ch_enable` in CH_NUM: per-channel `pkt_enable` from the channel stages.
- `out_sop` out CH_NUM: per-channel start pulse.
- `out_eop` out CH_NUM: per-channel end pulse.
- `out_vld` out CH_NUM: per-channel valid, high from `sop` through `eop` inclusive.
- `out_data` out 32: shared data bus, zero when no channel is valid.
- `err_trunc` out 1: one-cycle pulse when a packet is truncated.
- `err_drop` out 1: one-cycle pulse when a packet is dropped.
- `stat_pkt_in` out 32: count of committed packets.
- `stat_pkt_out` out 32: count of issued packets.
- `stat_err` out 32: count of truncated plus dropped packets.

## Operation
- **Write side, states W_IDLE and W_PKT.**
  - W_IDLE: `in_vld & in_sop & in_ready` stores the word and enters W_PKT, or commits directly if `in_eop` is also set.
  - W_IDLE: `in_vld & in_sop & ~in_ready` drops the whole packet up to its `in_eop`, pulses `err_drop`, and returns to W_IDLE.
  - W_IDLE: a word with `in_vld` and no `in_sop` is discarded silently.
  - W_PKT: every `in_vld` word is stored. `in_sop` is ignored and the word is treated as data.
  - W_PKT: the word with `in_eop` set commits the packet, increments `pkt_cnt`, and returns to W_IDLE.
- **Truncation.** If word number MAX_PKT_LEN arrives without `in_eop`, it is stored with eop=1 and the packet is committed. Input is then discarded up to and including `in_eop`, and `err_trunc` pulses once.
- **Ready and pointers.**
  - `in_ready` = free words ≥ MAX_PKT_LEN, so a started packet can never overflow the buffer.
  - Pointers are ADDR_W+1 bits and wrap naturally.
  - Full is when the pointers differ only in the MSB.
  - Uncommitted words are invisible to the read side.
- **Read side, states R_IDLE → R_ARB → R_SEND → R_GAP → R_IDLE.**
  - R_IDLE: go to R_ARB when `pkt_cnt` > 0.
  - R_ARB: search `ch_enable` round-robin starting at `last_grant+1`. Grant the first set bit k, latch k, and go to R_SEND. If no bit is set, stay in R_ARB.
  - R_SEND: drive one word per cycle on channel k, with no gaps, until the stored eop word. Then decrement `pkt_cnt` and go to R_GAP.
  - R_GAP: one idle cycle, then R_IDLE.
- **Shared counter.** A write commit and a read completion in the same cycle leave `pkt_cnt` unchanged.
- **Single active channel.** At most one channel has `out_vld` high at any time. Bits of `out_*` for non-granted channels are 0.

## Timing
- **Reset values.** All outputs are 0, except `in_ready` = 1 once the pointers are equal. Buffered packets are lost. Both FSMs go to their IDLE states. `last_grant` = CH_NUM-1, so channel 0 is granted first.
- **Reset during operation.** Reset forces all `out_*` to 0 immediately and asynchronously. A packet cut off by reset is never completed.
- **Grant to start.** `ch_enable[k]` is sampled in the R_ARB cycle t. `out_sop[k]`, `out_vld[k]` and word 0 appear at t+1.
  - Channel stages only drop enable on accepting a `sop`, so enable holds until the `sop` arrives.
- **Commit to start.** The input `eop` accepted at cycle e (buffer empty, channel enabled) gives the earliest `out_sop` at e+3.
- **Stream timing.** An L-word packet occupies L consecutive cycles. The `eop` comes at sop+L-1; for L = 1, `sop` and `eop` are in the same cycle.
- **Packet spacing.** Consecutive issued packets, on any channels, are separated by at least one idle cycle.
- **Buffer read.** The RAM is synchronous read, prefetched so that R_SEND never stalls.

## Configuration
- `DISPATCH_STAT_EN` defined: `stat_pkt_in`, `stat_pkt_out` and `stat_err` are 32-bit wrapping counters, cleared by reset.
- `DISPATCH_STAT_EN` undefined: the three stat ports are tied to 0 and no counter logic is built.
- `err_trunc`, `err_drop` and all other behaviour are identical either way.

## Test plan
- **Single packet.** One 5-word packet, `ch_enable` = 4'b0001 → `out_sop[0]` at eop+3, 5 consecutive words in order, `out_eop[0]` on word 5, other channels stay 0.
- **Round-robin with a busy channel.** Four 3-word packets, all channels enabled, channel 2 dropping enable after its packet → grants 0,1,2,3. A fifth packet goes to channel 0, skipping 2 if it is disabled, with one idle cycle between packets.
- **Input gaps.** A 4-word packet with `in_vld` low for 3 cycles mid-packet → output has no gaps, and nothing issues before the input `eop`.
- **Overlength packet.** 300-word packet with MAX_PKT_LEN = 256 → 256 words out, eop on word 256, `err_trunc` pulses once, and the following packet is intact.
- **Buffer full.** Fill the buffer until `in_ready` = 0 with all channels disabled, then send a `sop` → `err_drop` pulses and that packet never appears. Enable a channel → all buffered packets drain in order, and `stat_err` = 1 with the macro defined, 0 without.
- **Reset mid-stream.** Assert reset on word 3 of a 10-word output packet → `out_*` go to 0 at once. After release `in_ready` = 1 and no residual packet issues.

Source files
------------

// File: rtl/matrix_pkt_dispatch.sv
// Store-and-forward packet dispatcher: buffers whole packets and issues each one gap-free to an
// enabled channel stage, chosen round-robin. Define DISPATCH_STAT_EN to build the stat counters.
module matrix_pkt_dispatch #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MAX_PKT_LEN = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_vld,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic [CH_NUM-1:0] ch_enable,
  output logic [CH_NUM-1:0] out_sop,
  output logic [CH_NUM-1:0] out_eop,
  output logic [CH_NUM-1:0] out_vld,
  output logic [31:0]       out_data,
  output logic              err_trunc,
  output logic              err_drop,
  output logic [31:0]       stat_pkt_in,
  output logic [31:0]       stat_pkt_out,
  output logic [31:0]       stat_err
);
  localparam int unsigned CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned LEN_W   = $clog2(MAX_PKT_LEN) + 1;
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned DEPTH_I = 2 ** ADDR_W;
  localparam int unsigned MAXL_I  = MAX_PKT_LEN;
  localparam logic [PTR_W:0]     DEPTH    = DEPTH_I[PTR_W:0];
  localparam logic [PTR_W:0]     MAX_LEN  = MAXL_I[PTR_W:0];
  localparam logic [LEN_W-1:0]   LAST_LEN = LEN_W'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {WIdle, WPkt, WDiscard} w_state_e;
  typedef enum logic [1:0] {RIdle, RArb, RSend, RGap} r_state_e;

  w_state_e          w_state_q;
  r_state_e          r_state_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d, pkt_cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [CH_W-1:0]   last_grant_q, grant_idx, rr_idx;
  logic [CH_NUM-1:0] grant_mask;
  logic              grant_found;
  logic [32:0]       mem [DEPTH_I];
  logic [32:0]       rdata_q;
  logic [PTR_W:0]    used, free;
  logic              wr_en, wr_eop, commit, trunc, drop, done, rd_adv;

  // Free space counts uncommitted words, so a started packet always fits.
  assign used     = {1'b0, wr_ptr_q - rd_ptr_q};
  assign free     = DEPTH - used;
  assign in_ready = (free >= MAX_LEN);

  always_comb begin
    wr_en  = 1'b0;
    commit = 1'b0;
    trunc  = 1'b0;
    drop   = 1'b0;
    case (w_state_q)
      WIdle: if (in_vld && in_sop) begin
        if (in_ready) begin
          wr_en  = 1'b1;
          commit = in_eop || (MAX_PKT_LEN == 1);
          trunc  = !in_eop && (MAX_PKT_LEN == 1);
        end else begin
          drop = 1'b1;
        end
      end
      WPkt: if (in_vld) begin
        wr_en  = 1'b1;
        commit = in_eop || (len_q == LAST_LEN);
        trunc  = !in_eop && (len_q == LAST_LEN);
      end
      default: ;
    endcase
    wr_eop = in_eop || trunc;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_state_q <= WIdle;
      wr_ptr_q  <= '0;
      len_q     <= '0;
      err_trunc <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_trunc <= trunc;
      err_drop  <= drop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      case (w_state_q)
        WIdle: begin
          len_q <= LEN_W'(1);
          if (trunc || (drop && !in_eop)) w_state_q <= WDiscard;
          else if (wr_en && !commit)      w_state_q <= WPkt;
        end
        WPkt: if (in_vld) begin
          len_q <= len_q + LEN_W'(1);
          if (trunc)       w_state_q <= WDiscard;
          else if (commit) w_state_q <= WIdle;
        end
        WDiscard: if (in_vld && in_eop) w_state_q <= WIdle;
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      rr_idx = CH_W'((32'(last_grant_q) + i) % CH_NUM);
      if (!grant_found && ch_enable[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  assign grant_mask = CH_NUM'(1) << grant_idx;
  assign done       = (r_state_q == RSend) && (|out_eop);
  assign rd_adv     = ((r_state_q == RArb) && grant_found) || ((r_state_q == RSend) && !(|out_eop));
  assign rd_ptr_d   = rd_ptr_q + PTR_W'(rd_adv);

  // rdata_q always holds the word at rd_ptr_q, so the next word is ready without a stall.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_eop, in_data};
    rdata_q <= mem[rd_ptr_d[ADDR_W-1:0]];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state_q    <= RIdle;
      rd_ptr_q     <= '0;
      last_grant_q <= CH_W'(CH_NUM - 1);
      out_sop      <= '0;
      out_eop      <= '0;
      out_vld      <= '0;
      out_data     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      out_sop  <= '0;
      case (r_state_q)
        RIdle: if (pkt_cnt_q != '0) r_state_q <= RArb;
        RArb: if (grant_found) begin
          last_grant_q <= grant_idx;
          out_sop      <= grant_mask;
          out_vld      <= grant_mask;
          out_eop      <= rdata_q[32] ? grant_mask : '0;
          out_data     <= rdata_q[31:0];
          r_state_q    <= RSend;
        end
        RSend: if (|out_eop) begin
          out_vld   <= '0;
          out_eop   <= '0;
          out_data  <= '0;
          r_state_q <= RGap;
        end else begin
          out_eop  <= rdata_q[32] ? out_vld : '0;
          out_data <= rdata_q[31:0];
        end
        RGap: r_state_q <= RIdle;
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_cnt_q <= '0;
    end else if (commit && !done) begin
      pkt_cnt_q <= pkt_cnt_q + PTR_W'(1);
    end else if (!commit && done) begin
      pkt_cnt_q <= pkt_cnt_q - PTR_W'(1);
    end
  end

`ifdef DISPATCH_STAT_EN
  logic [31:0] stat_in_q, stat_out_q, stat_err_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (commit)        stat_in_q  <= stat_in_q + 32'd1;
      if (done)          stat_out_q <= stat_out_q + 32'd1;
      if (trunc || drop) stat_err_q <= stat_err_q + 32'd1;
    end
  end

  assign stat_pkt_in  = stat_in_q;
  assign stat_pkt_out = stat_out_q;
  assign stat_err     = stat_err_q;
`else
  assign stat_pkt_in  = '0;
  assign stat_pkt_out = '0;
  assign stat_err     = '0;
`endif

endmodule

// File: tb/tb_matrix_pkt_dispatch.sv
// Directed bench for matrix_pkt_dispatch: a negedge monitor logs every issued word, and the
// directed steps compare the log against hand-derived packets, timing and error pulses.
module tb_matrix_pkt_dispatch;
  localparam int CH = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic [CH-1:0] ch_enable = '0;
  logic [CH-1:0] out_sop, out_eop, out_vld;
  logic [31:0]   out_data;
  logic          err_trunc, err_drop;
  logic [31:0]   stat_pkt_in, stat_pkt_out, stat_err;

  matrix_pkt_dispatch #(.CH_NUM(CH), .ADDR_W(10), .MAX_PKT_LEN(256)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ch_enable   (ch_enable),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .err_trunc   (err_trunc),
    .err_drop    (err_drop),
    .stat_pkt_in (stat_pkt_in),
    .stat_pkt_out(stat_pkt_out),
    .stat_err    (stat_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {int ch; logic sop; logic eop; logic [31:0] data; int cyc;} rec_t;
  rec_t log_q[$];
  rec_t mon_rec;
  int   cyc = 0, viol = 0, trunc_cnt = 0, drop_cnt = 0;
  int   n_assert = 0, n_fail = 0, last_eop_cyc = -100;
  int   e, base, found;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Each sample is tagged with the number of rising edges seen so far.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if ($countones(out_vld) > 1 || ((out_sop | out_eop) & ~out_vld) != '0 ||
          (out_vld == '0 && out_data != '0)) viol++;
      if (out_vld != '0) begin
        for (int k = 0; k < CH; k++) if (out_vld[k]) mon_rec.ch = k;
        mon_rec.sop  = |out_sop;
        mon_rec.eop  = |out_eop;
        mon_rec.data = out_data;
        mon_rec.cyc  = cyc;
        log_q.push_back(mon_rec);
      end
      if (err_trunc) trunc_cnt++;
      if (err_drop)  drop_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    chk({tag, "_arrived"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  // Word i of packet id carries {id, i}; eop_cyc is the edge on which the eop word is taken.
  task automatic send_pkt(input int len, input int id, input int gap_at, input int gap_len,
                          output int eop_cyc);
    eop_cyc = 0;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        repeat (gap_len) @(posedge sys_clk);
        #1;
      end
      in_vld  = 1'b1;
      in_sop  = (i == 0);
      in_eop  = (i == len - 1);
      in_data = {16'(id), 16'(i)};
      @(posedge sys_clk);
      #1;
      eop_cyc = cyc;
    end
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic check_pkt(input string tag, input int ch, input int len, input int id,
                           input int first_cyc);
    rec_t w;
    int prev_cyc = 0;
    logic gap_ok;
    logic [42:0] got, exp;
    wait_log(len, len + 80, tag);
    for (int i = 0; i < len && log_q.size() > 0; i++) begin
      w = log_q.pop_front();
      gap_ok = (i == 0) ? (w.cyc - last_eop_cyc >= 2) : (w.cyc == prev_cyc + 1);
      prev_cyc = w.cyc;
      got = {8'(w.ch), w.sop, w.eop, w.data, gap_ok};
      exp = {8'(ch), (i == 0), (i == len - 1), {16'(id), 16'(i)}, 1'b1};
      n_assert++;
      assert (got === exp) else begin
        n_fail++;
        $error("FAIL %s word %0d: got ch=%0d sop=%0b eop=%0b data=%08h spacing_ok=%0b, expected ch=%0d sop=%0b eop=%0b data=%08h spacing_ok=1",
               tag, i, w.ch, w.sop, w.eop, w.data, gap_ok, ch, (i == 0), (i == len - 1),
               {16'(id), 16'(i)});
      end
      if (i == 0 && first_cyc >= 0) chk({tag, "_sop_time"}, 32'(w.cyc), 32'(first_cyc));
      if (w.eop) last_eop_cyc = w.cyc;
    end
  endtask

  task automatic do_reset();
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    log_q.delete();
    last_eop_cyc = -100;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_out_sop_eop", 32'(out_sop | out_eop), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", 32'({err_trunc, err_drop}), 0);
    chk("rst_stats", stat_pkt_in | stat_pkt_out | stat_err, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    sys_rst_n = 1'b1;

    // Single 5-word packet to channel 0: sop lands two edges after the eop edge (cycle e+3)
    ch_enable = 4'b0001;
    send_pkt(5, 1, -1, 0, e);
    check_pkt("single", 0, 5, 1, e + 2);

    // Round robin 0,1,2,3; channel 2 then drops enable, so 0,1,3 follow
    do_reset();
    ch_enable = 4'b1111;
    for (int p = 0; p < 4; p++) send_pkt(3, 10 + p, -1, 0, e);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      foreach (log_q[j]) if (log_q[j].ch == 2 && log_q[j].sop) found = 1;
      if (found == 0) begin
        @(negedge sys_clk);
        #1;
      end
    end
    chk("rr_ch2_granted", 32'(found), 1);
    ch_enable[2] = 1'b0;
    for (int p = 4; p < 7; p++) send_pkt(3, 10 + p, -1, 0, e);
    check_pkt("rr_a", 0, 3, 10, -1);
    check_pkt("rr_b", 1, 3, 11, -1);
    check_pkt("rr_c", 2, 3, 12, -1);
    check_pkt("rr_d", 3, 3, 13, -1);
    check_pkt("rr_e", 0, 3, 14, -1);
    check_pkt("rr_f", 1, 3, 15, -1);
    check_pkt("rr_skip2", 3, 3, 16, -1);

    // Input gaps: nothing may issue before the input eop, and the output is gap-free
    ch_enable = 4'b0001;
    send_pkt(4, 20, 2, 3, e);
    chk("gap_no_early_issue", 32'(log_q.size()), 0);
    check_pkt("gap_pkt", 0, 4, 20, e + 2);

    // Overlength: 300 words truncated to 256, next packet intact
    base = trunc_cnt;
    send_pkt(300, 30, -1, 0, e);
    send_pkt(4, 31, -1, 0, e);
    check_pkt("trunc_pkt", 0, 256, 30, -1);
    check_pkt("after_trunc", 0, 4, 31, -1);
    chk("trunc_pulses", 32'(trunc_cnt - base), 1);

    // Reset during word 3 of a 10-word packet
    send_pkt(10, 50, -1, 0, e);
    wait_log(3, 40, "midrst");
    #1 sys_rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", 32'(out_vld), 0);
    chk("midrst_out_sop_eop", 32'(out_sop | out_eop), 0);
    chk("midrst_out_data", out_data, 0);
    log_q.delete();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    last_eop_cyc = -100;
    chk("midrst_in_ready", 32'(in_ready), 1);
    repeat (30) @(posedge sys_clk);
    #1;
    chk("midrst_no_residual", 32'(log_q.size()), 0);

    // Buffer full: four 200-word packets leave 224 free words, so the fifth sop is dropped
    do_reset();
    ch_enable = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      chk("fill_ready", 32'(in_ready), 1);
      send_pkt(200, 40 + p, -1, 0, e);
    end
    chk("full_not_ready", 32'(in_ready), 0);
    base = drop_cnt;
    send_pkt(5, 44, -1, 0, e);
    chk("drop_pulses", 32'(drop_cnt - base), 1);
    repeat (10) @(posedge sys_clk);
    #1;
    chk("disabled_no_issue", 32'(log_q.size()), 0);
    ch_enable = 4'b0001;
    for (int p = 0; p < 4; p++) check_pkt("drain", 0, 200, 40 + p, -1);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("dropped_never_issued", 32'(log_q.size()), 0);
    chk("drained_ready", 32'(in_ready), 1);
`ifdef DISPATCH_STAT_EN
    chk("stat_err", stat_err, 1);
    chk("stat_pkt_in", stat_pkt_in, 4);
    chk("stat_pkt_out", stat_pkt_out, 4);
`else
    chk("stat_err", stat_err, 0);
    chk("stat_pkt_in", stat_pkt_in, 0);
    chk("stat_pkt_out", stat_pkt_out, 0);
`endif

    chk("single_active_channel", 32'(viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
